map_left_right: RTL



---
 rtl/map_left_right_if.sv | 32 +++
 rtl/map_left_right.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/map_left_right_if.sv
// Bus between the top/bottom mapper, the frame-buffer ROM and the star-record
// stage as seen by the left/right mapper (slave) and whoever drives it (master).
interface map_left_right_if #(
    parameter int X_SZ    = 8,
    parameter int Y_SZ    = 7,
    parameter int ADDR_SZ = 15,
    parameter int COL_SZ  = 3
);
    logic               tbFound;
    logic [X_SZ-1:0]    midPix;
    logic [Y_SZ-1:0]    mostTop;
    logic [Y_SZ-1:0]    mostBottom;
    logic [ADDR_SZ-1:0] memAddr;
    logic [COL_SZ-1:0]  memQ;
    logic [X_SZ-1:0]    mostLeft;
    logic [X_SZ-1:0]    mostRight;
    logic [X_SZ-1:0]    centreX;
    logic [Y_SZ-1:0]    centreY;
    logic               busy;
    logic               lrFound;

    // tbFound and lrFound are single-cycle pulses with no ready/back-pressure:
    // a request is taken only while busy is low, results are valid while lrFound is high.
    modport master (
        output tbFound, midPix, mostTop, mostBottom, memQ,
        input  memAddr, mostLeft, mostRight, centreX, centreY, busy, lrFound
    );
    modport slave (
        input  tbFound, midPix, mostTop, mostBottom, memQ,
        output memAddr, mostLeft, mostRight, centreX, centreY, busy, lrFound
    );
endinterface

// File: rtl/map_left_right.sv
// Scans the middle row of a star left then right from its column to find the
// horizontal extent, then reports the extent, the centre and a done pulse.
module map_left_right #(
    parameter int X_SZ      = 8,
    parameter int Y_SZ      = 7,
    parameter int ADDR_SZ   = 15,
    parameter int COL_SZ    = 3,
    parameter int X_RES     = 160,
    parameter int THRESHOLD = 0
) (
    input  logic                 clk,
    input  logic                 resetn,
    map_left_right_if.slave      bus,
    output logic [2:0]           dbg_state_o
);
    typedef enum logic [2:0] {
        IDLE, LATCH, L_REQ, L_CHK, R_REQ, R_CHK, DONE
    } state_t;

    localparam logic [X_SZ-1:0] X_MAX = X_SZ'(X_RES - 1);

    state_t             state_q, state_d;
    logic [X_SZ-1:0]    mid_q, mid_d, x_q, x_d;
    logic [X_SZ-1:0]    left_q, left_d, right_q, right_d, cx_q, cx_d;
    logic [Y_SZ-1:0]    top_q, top_d, bot_q, bot_d, row_q, row_d, cy_q, cy_d;
    logic [ADDR_SZ-1:0] addr_q, addr_d;
    logic               busy_q, busy_d, found_q, found_d;
    logic               bright;
    logic [Y_SZ:0]      row_sum;
    logic [X_SZ:0]      cx_sum;

    // row*160 as (row<<7)+(row<<5), so no multiplier is needed
    function automatic logic [ADDR_SZ-1:0] addr_of(input logic [Y_SZ-1:0] row,
                                                   input logic [X_SZ-1:0] x);
        return (ADDR_SZ'(row) << 7) + (ADDR_SZ'(row) << 5) + ADDR_SZ'(x);
    endfunction

    always_comb begin
        state_d = state_q;
        mid_d   = mid_q;
        x_d     = x_q;
        left_d  = left_q;
        right_d = right_q;
        cx_d    = cx_q;
        top_d   = top_q;
        bot_d   = bot_q;
        row_d   = row_q;
        cy_d    = cy_q;
        addr_d  = addr_q;
        found_d = 1'b0;
        row_sum = {1'b0, top_q} + {1'b0, bot_q};
        bright  = (bus.memQ != COL_SZ'(THRESHOLD));

        case (state_q)
            IDLE: begin
                if (bus.tbFound) begin
                    mid_d   = bus.midPix;
                    top_d   = bus.mostTop;
                    bot_d   = bus.mostBottom;
                    state_d = LATCH;
                end
            end
            LATCH: begin
                row_d   = row_sum[Y_SZ:1];
                x_d     = mid_q;
                addr_d  = addr_of(row_d, mid_q);
                state_d = L_REQ;
            end
            L_REQ: state_d = L_CHK;
            L_CHK: begin
                if (!bright && x_q == mid_q) begin
                    left_d  = mid_q;
                    right_d = mid_q;
                    state_d = DONE;
                end else if (bright && x_q != '0) begin
                    x_d     = x_q - 1'b1;
                    addr_d  = addr_of(row_q, x_q - 1'b1);
                    state_d = L_REQ;
                end else begin
                    left_d = bright ? '0 : x_q + 1'b1;
                    // a star sitting on the last column has nothing to its right
                    if (mid_q == X_MAX) begin
                        right_d = mid_q;
                        state_d = DONE;
                    end else begin
                        x_d     = mid_q + 1'b1;
                        addr_d  = addr_of(row_q, mid_q + 1'b1);
                        state_d = R_REQ;
                    end
                end
            end
            R_REQ: state_d = R_CHK;
            R_CHK: begin
                if (!bright) begin
                    right_d = x_q - 1'b1;
                    state_d = DONE;
                end else if (x_q == X_MAX) begin
                    right_d = X_MAX;
                    state_d = DONE;
                end else begin
                    x_d     = x_q + 1'b1;
                    addr_d  = addr_of(row_q, x_q + 1'b1);
                    state_d = R_REQ;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // results are registered on entry to DONE so they line up with lrFound
        cx_sum = {1'b0, left_d} + {1'b0, right_d};
        if (state_d == DONE) begin
            cx_d    = cx_sum[X_SZ:1];
            cy_d    = row_q;
            found_d = 1'b1;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            mid_q   <= '0;
            x_q     <= '0;
            left_q  <= '0;
            right_q <= '0;
            cx_q    <= '0;
            top_q   <= '0;
            bot_q   <= '0;
            row_q   <= '0;
            cy_q    <= '0;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            found_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mid_q   <= mid_d;
            x_q     <= x_d;
            left_q  <= left_d;
            right_q <= right_d;
            cx_q    <= cx_d;
            top_q   <= top_d;
            bot_q   <= bot_d;
            row_q   <= row_d;
            cy_q    <= cy_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            found_q <= found_d;
        end
    end

    assign bus.memAddr   = addr_q;
    assign bus.mostLeft  = left_q;
    assign bus.mostRight = right_q;
    assign bus.centreX   = cx_q;
    assign bus.centreY   = cy_q;
    assign bus.busy      = busy_q;
    assign bus.lrFound   = found_q;
    assign dbg_state_o   = state_q;
endmodule
